// File: rtl/alu_operand_stage_if.sv
// ---------------------------------------------------------------------------
// alu_operand_stage_if
//   Bundles the decode-side handshake and op fields, the MEM/WB writer
//   snoop buses, the flush strobe and the EX-side handshake/operand bus of
//   the ID->EX operand stage.
//   Modports:
//     master : the surrounding pipeline. It drives decode, snoop, flush and
//              ex_ready, and receives id_ready and the EX operand bus.
//     slave  : alu_operand_stage itself.
//   Parameters:
//     XLEN : datapath width
//     REGW : register-address width
// ---------------------------------------------------------------------------
interface alu_operand_stage_if #(
  parameter int XLEN = 32,
  parameter int REGW = 5
);
  // pipeline control
  logic                   flush;

  // decode side
  logic                   id_valid;
  logic                   id_ready;
  logic [REGW-1:0]        id_rs1_addr;
  logic [REGW-1:0]        id_rs2_addr;
  logic [REGW-1:0]        id_rd_addr;
  logic [XLEN-1:0]        id_rs1_data;
  logic [XLEN-1:0]        id_rs2_data;
  logic [XLEN-1:0]        id_pc;
  logic [XLEN-1:0]        id_imm;
  logic                   id_a_is_pc;
  logic                   id_b_is_imm;
  logic [3:0]             id_alu_op;

  // writer snoop (MEM and WB stages)
  logic                   mem_wen;
  logic [REGW-1:0]        mem_rd;
  logic [XLEN-1:0]        mem_data;
  logic                   wb_wen;
  logic [REGW-1:0]        wb_rd;
  logic [XLEN-1:0]        wb_data;

  // EX side
  logic                   ex_valid;
  logic                   ex_ready;
  logic signed [XLEN-1:0] alu_input_a;
  logic signed [XLEN-1:0] alu_input_b;
  logic [3:0]             alu_op;
  logic [REGW-1:0]        ex_rd_addr;

  modport master (
    output flush,
    output id_valid, id_rs1_addr, id_rs2_addr, id_rd_addr,
    output id_rs1_data, id_rs2_data, id_pc, id_imm,
    output id_a_is_pc, id_b_is_imm, id_alu_op,
    output mem_wen, mem_rd, mem_data, wb_wen, wb_rd, wb_data,
    output ex_ready,
    input  id_ready,
    input  ex_valid, alu_input_a, alu_input_b, alu_op, ex_rd_addr
  );

  modport slave (
    input  flush,
    input  id_valid, id_rs1_addr, id_rs2_addr, id_rd_addr,
    input  id_rs1_data, id_rs2_data, id_pc, id_imm,
    input  id_a_is_pc, id_b_is_imm, id_alu_op,
    input  mem_wen, mem_rd, mem_data, wb_wen, wb_rd, wb_data,
    input  ex_ready,
    output id_ready,
    output ex_valid, alu_input_a, alu_input_b, alu_op, ex_rd_addr
  );
endinterface

// File: rtl/alu_operand_stage.sv
// ---------------------------------------------------------------------------
// alu_operand_stage
//   ID->EX operand stage in front of the ALU. Decoded ops are held in a
//   2-entry skid buffer (main = head presented to EX, skid = overflow).
//   Operand sources are selected per op (register / PC / immediate), and
//   RAW hazards are resolved by forwarding from the MEM and WB stages.
//
//   Ports:
//     clk   : clock, rising edge
//     nRst  : asynchronous active-low reset; drops every held entry
//     bus   : alu_operand_stage_if.slave
//             flush                 - kill all held entries
//             id_valid/id_ready     - decode handshake
//             id_*                  - decoded op fields and regfile reads
//             mem_*/wb_*            - writer snoop buses
//             ex_valid/ex_ready     - EX handshake
//             alu_input_a/b, alu_op, ex_rd_addr - operand bus to the ALU
//
//   Configuration macro:
//     ALU_FWD_EN - when defined, MEM/WB forwarding at the output and the
//                  WB refresh of held entries are enabled. When undefined,
//                  the mem_*/wb_* buses are ignored and operands come only
//                  from the captured regfile data (x0 still reads as 0).
// ---------------------------------------------------------------------------
module alu_operand_stage #(
  parameter int XLEN = 32,
  parameter int REGW = 5
) (
  input  logic            clk,
  input  logic            nRst,
  alu_operand_stage_if.slave bus
);

  typedef struct packed {
    logic [REGW-1:0] rs1_addr;
    logic [REGW-1:0] rs2_addr;
    logic [REGW-1:0] rd_addr;
    logic [XLEN-1:0] rs1_data;
    logic [XLEN-1:0] rs2_data;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] imm;
    logic            a_is_pc;
    logic            b_is_imm;
    logic [3:0]      alu_op;
  } entry_t;

  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_ONE   = 2'd1,
    S_TWO   = 2'd2
  } state_t;

  state_t state_reg, state_next;
  entry_t main_reg, skid_reg;
  entry_t id_entry, main_hold, skid_hold;

  logic load_main_id;
  logic load_main_skid;
  logic load_skid_id;
  logic main_valid;

  logic [XLEN-1:0] rs1_val;
  logic [XLEN-1:0] rs2_val;

`ifdef ALU_FWD_EN
  logic            mem_wen;
  logic [REGW-1:0] mem_rd;
  logic [XLEN-1:0] mem_data;
  logic            wb_wen;
  logic [REGW-1:0] wb_rd;
  logic [XLEN-1:0] wb_data;

  assign mem_wen  = bus.mem_wen;
  assign mem_rd   = bus.mem_rd;
  assign mem_data = bus.mem_data;
  assign wb_wen   = bus.wb_wen;
  assign wb_rd    = bus.wb_rd;
  assign wb_data  = bus.wb_data;

  // A writer leaving WB is about to land in the regfile; any entry that
  // captured (or is capturing) the old value must pick it up now, or the
  // update is lost once the writer has retired.
  function automatic entry_t wb_refresh(input entry_t e);
    entry_t r;
    r = e;
    if (wb_wen && (wb_rd != '0)) begin
      if (e.rs1_addr == wb_rd) r.rs1_data = wb_data;
      if (e.rs2_addr == wb_rd) r.rs2_data = wb_data;
    end
    return r;
  endfunction

  // Newest value wins: MEM is younger than WB, which is younger than the
  // stored (refreshed) copy.
  function automatic logic [XLEN-1:0] resolve(input logic [REGW-1:0] addr,
                                              input logic [XLEN-1:0] stored);
    logic [XLEN-1:0] v;
    if (addr == '0)                          v = '0;
    else if (mem_wen && (mem_rd == addr))    v = mem_data;
    else if (wb_wen && (wb_rd == addr))      v = wb_data;
    else                                     v = stored;
    return v;
  endfunction
`else
  // Snoop buses are intentionally ignored in this build.
  logic unused_snoop;
  assign unused_snoop = ^{bus.mem_wen, bus.mem_rd, bus.mem_data,
                          bus.wb_wen, bus.wb_rd, bus.wb_data};

  function automatic logic [XLEN-1:0] resolve(input logic [REGW-1:0] addr,
                                              input logic [XLEN-1:0] stored);
    logic [XLEN-1:0] v;
    if (addr == '0) v = '0;
    else            v = stored;
    return v;
  endfunction
`endif

  // ---------------------------------------------------------------------
  // Buffer FSM
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) state_reg <= S_EMPTY;
    else       state_reg <= state_next;
  end

  always_comb begin
    state_next     = state_reg;
    load_main_id   = 1'b0;
    load_main_skid = 1'b0;
    load_skid_id   = 1'b0;
    case (state_reg)
      S_EMPTY: begin
        if (bus.id_valid) begin
          load_main_id = 1'b1;
          state_next   = S_ONE;
        end
      end
      S_ONE: begin
        if (bus.ex_ready) begin
          if (bus.id_valid) load_main_id = 1'b1;
          else              state_next   = S_EMPTY;
        end else if (bus.id_valid) begin
          load_skid_id = 1'b1;
          state_next   = S_TWO;
        end
      end
      S_TWO: begin
        // decode is back-pressured; only the drain matters here
        if (bus.ex_ready) begin
          load_main_skid = 1'b1;
          state_next     = S_ONE;
        end
      end
      default: state_next = S_EMPTY;
    endcase
    // flush beats any accept/consume in the same cycle
    if (bus.flush) begin
      state_next     = S_EMPTY;
      load_main_id   = 1'b0;
      load_main_skid = 1'b0;
      load_skid_id   = 1'b0;
    end
  end

  // ---------------------------------------------------------------------
  // Entry storage
  // ---------------------------------------------------------------------
  always_comb begin
    id_entry          = '0;
    id_entry.rs1_addr = bus.id_rs1_addr;
    id_entry.rs2_addr = bus.id_rs2_addr;
    id_entry.rd_addr  = bus.id_rd_addr;
    id_entry.rs1_data = bus.id_rs1_data;
    id_entry.rs2_data = bus.id_rs2_data;
    id_entry.pc       = bus.id_pc;
    id_entry.imm      = bus.id_imm;
    id_entry.a_is_pc  = bus.id_a_is_pc;
    id_entry.b_is_imm = bus.id_b_is_imm;
    id_entry.alu_op   = bus.id_alu_op;
    main_hold         = main_reg;
    skid_hold         = skid_reg;
`ifdef ALU_FWD_EN
    id_entry  = wb_refresh(id_entry);
    main_hold = wb_refresh(main_reg);
    skid_hold = wb_refresh(skid_reg);
`endif
  end

  // Validity lives in the FSM state; payloads of invalid entries are don't
  // care, so they are simply left to refresh alongside the live ones.
  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      main_reg <= '0;
      skid_reg <= '0;
    end else begin
      if (load_main_id)        main_reg <= id_entry;
      else if (load_main_skid) main_reg <= skid_hold;
      else                     main_reg <= main_hold;

      if (load_skid_id) skid_reg <= id_entry;
      else              skid_reg <= skid_hold;
    end
  end

  // ---------------------------------------------------------------------
  // Handshake and operand outputs
  // ---------------------------------------------------------------------
  assign main_valid   = (state_reg != S_EMPTY);
  assign bus.id_ready = (state_reg != S_TWO);
  assign bus.ex_valid = main_valid;

  always_comb begin
    rs1_val = resolve(main_reg.rs1_addr, main_reg.rs1_data);
    rs2_val = resolve(main_reg.rs2_addr, main_reg.rs2_data);
  end

  // Outputs are zeroed while nothing is held so the ALU sees a clean bus
  // after reset or flush.
  assign bus.alu_input_a = !main_valid        ? '0 :
                           main_reg.a_is_pc   ? main_reg.pc  : rs1_val;
  assign bus.alu_input_b = !main_valid        ? '0 :
                           main_reg.b_is_imm  ? main_reg.imm : rs2_val;
  assign bus.alu_op      = main_valid ? main_reg.alu_op  : 4'd0;
  assign bus.ex_rd_addr  = main_valid ? main_reg.rd_addr : '0;

endmodule

// File: tb/tb_alu_operand_stage.sv
// ---------------------------------------------------------------------------
// tb_alu_operand_stage
//   Scoreboard bench. The driver models a small pipeline around the stage
//   (regfile array, a MEM writer slot and a WB writer slot) and pushes each
//   accepted op into a queue. The monitor checks the handshake against the
//   queue occupancy and, on each consume, pops the oldest op and derives the
//   operands from the architectural rules: x0 is zero, otherwise the newest
//   producer (MEM, then WB, then the regfile) when forwarding is built in,
//   or the data captured from the regfile when it is not.
// ---------------------------------------------------------------------------
module tb_alu_operand_stage;
  localparam int XLEN = 32;
  localparam int REGW = 5;

  logic clk = 1'b0;
  logic nRst;
  always #5 clk = ~clk;

  alu_operand_stage_if #(.XLEN(XLEN), .REGW(REGW)) bus();

  alu_operand_stage #(.XLEN(XLEN), .REGW(REGW)) dut (
    .clk  (clk),
    .nRst (nRst),
    .bus  (bus)
  );

  typedef struct {
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [31:0] d1;
    logic [31:0] d2;
    logic [31:0] pc;
    logic [31:0] imm;
    logic        a_pc;
    logic        b_imm;
    logic [3:0]  op;
  } op_t;

  op_t         sb[$];
  op_t         cur_op;
  logic [31:0] rf [32];
  int          vectors = 0;
  int          miscompares = 0;
  int          txn = 0;
  logic        exp_ready = 1'b1;
  logic        mon_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] src_val(input logic [4:0] a, input logic [31:0] cap);
    logic [31:0] v;
    if (a == 5'd0) v = 32'd0;
`ifdef ALU_FWD_EN
    else if (bus.mem_wen && bus.mem_rd == a) v = bus.mem_data;
    else if (bus.wb_wen && bus.wb_rd == a)   v = bus.wb_data;
    else                                     v = rf[a];
    if (a == 5'd31 && cap === 32'hx) v = 32'hx;
`else
    else v = cap;
`endif
    return v;
  endfunction

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    op_t         e;
    logic [31:0] ea, eb;
    exp_ready = (sb.size() < 2);
    if (nRst && mon_en) begin
      check("ex_valid", {31'd0, bus.ex_valid}, {31'd0, sb.size() > 0});
      check("id_ready", {31'd0, bus.id_ready}, {31'd0, exp_ready});
      if (bus.ex_valid && bus.ex_ready && !bus.flush && sb.size() > 0) begin
        e  = sb.pop_front();
        ea = e.a_pc  ? e.pc  : src_val(e.rs1, e.d1);
        eb = e.b_imm ? e.imm : src_val(e.rs2, e.d2);
        $display("txn %0d: a=%h b=%h op=%h rd=%0d (exp a=%h b=%h op=%h rd=%0d)",
                 txn, bus.alu_input_a, bus.alu_input_b, bus.alu_op, bus.ex_rd_addr,
                 ea, eb, e.op, e.rd);
        txn++;
        check("alu_input_a", bus.alu_input_a, ea);
        check("alu_input_b", bus.alu_input_b, eb);
        check("alu_op", {28'd0, bus.alu_op}, {28'd0, e.op});
        check("ex_rd_addr", {27'd0, bus.ex_rd_addr}, {27'd0, e.rd});
      end
    end
  end

  // ---------------- driver ----------------
  task automatic drive_op(input logic [4:0] r1, input logic [4:0] r2, input logic [4:0] rd,
                          input logic [31:0] pc, input logic [31:0] imm,
                          input logic apc, input logic bimm, input logic [3:0] op);
    bus.id_valid    = 1'b1;
    bus.id_rs1_addr = r1;
    bus.id_rs2_addr = r2;
    bus.id_rd_addr  = rd;
    bus.id_rs1_data = rf[r1];
    bus.id_rs2_data = rf[r2];
    bus.id_pc       = pc;
    bus.id_imm      = imm;
    bus.id_a_is_pc  = apc;
    bus.id_b_is_imm = bimm;
    bus.id_alu_op   = op;
    cur_op = '{rs1: r1, rs2: r2, rd: rd, d1: rf[r1], d2: rf[r2], pc: pc, imm: imm,
               a_pc: apc, b_imm: bimm, op: op};
  endtask

  // One clock: record the accept/flush seen by the DUT, then advance the
  // writer pipeline (WB commits, MEM moves to WB, new MEM writer enters).
  task automatic tick(input logic mw, input logic [4:0] mr, input logic [31:0] md);
    @(negedge clk);
    #2;
    if (nRst) begin
      if (bus.flush)                        sb.delete();
      else if (bus.id_valid && exp_ready)   sb.push_back(cur_op);
    end
    @(posedge clk);
    #1;
    if (bus.wb_wen) rf[bus.wb_rd] = bus.wb_data;
    bus.wb_wen   = bus.mem_wen;
    bus.wb_rd    = bus.mem_rd;
    bus.wb_data  = bus.mem_data;
    bus.mem_wen  = mw;
    bus.mem_rd   = mr;
    bus.mem_data = md;
    bus.id_valid = 1'b0;
    bus.flush    = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) tick(1'b0, 5'd0, 32'd0);
  endtask

  initial begin
    nRst = 1'b0;
    bus.flush = 1'b0; bus.id_valid = 1'b0; bus.ex_ready = 1'b0;
    bus.id_rs1_addr = '0; bus.id_rs2_addr = '0; bus.id_rd_addr = '0;
    bus.id_rs1_data = '0; bus.id_rs2_data = '0; bus.id_pc = '0; bus.id_imm = '0;
    bus.id_a_is_pc = 1'b0; bus.id_b_is_imm = 1'b0; bus.id_alu_op = '0;
    bus.mem_wen = 1'b0; bus.mem_rd = '0; bus.mem_data = '0;
    bus.wb_wen = 1'b0; bus.wb_rd = '0; bus.wb_data = '0;
    cur_op = '{rs1: 0, rs2: 0, rd: 0, d1: 0, d2: 0, pc: 0, imm: 0, a_pc: 0, b_imm: 0, op: 0};
    for (int r = 0; r < 32; r++) rf[r] = $urandom;
    rf[0] = 32'hDEAD_BEEF;   // regfile garbage at x0 must never reach the ALU

    idle(2);
    check("reset ex_valid", {31'd0, bus.ex_valid}, 32'd0);
    check("reset id_ready", {31'd0, bus.id_ready}, 32'd1);
    check("reset alu_input_a", bus.alu_input_a, 32'd0);
    check("reset alu_input_b", bus.alu_input_b, 32'd0);
    check("reset alu_op", {28'd0, bus.alu_op}, 32'd0);
    check("reset ex_rd_addr", {27'd0, bus.ex_rd_addr}, 32'd0);
    nRst = 1'b1;
    mon_en = 1'b1;
    idle(1);

    // ADD x1(5) + x2(7)
    rf[1] = 32'd5; rf[2] = 32'd7;
    bus.ex_ready = 1'b1;
    drive_op(5'd1, 5'd2, 5'd10, 32'h100, 32'd0, 1'b0, 1'b0, 4'h0);
    tick(1'b0, 5'd0, 32'd0);
    idle(2);

    // back-pressure: two accepts fill the buffer, third is refused
    bus.ex_ready = 1'b0;
    drive_op(5'd4, 5'd5, 5'd11, 32'h200, 32'h1, 1'b0, 1'b0, 4'h1); tick(1'b0, 5'd0, 32'd0);
    drive_op(5'd6, 5'd7, 5'd12, 32'h204, 32'h2, 1'b1, 1'b1, 4'h2); tick(1'b0, 5'd0, 32'd0);
    drive_op(5'd8, 5'd9, 5'd13, 32'h208, 32'h3, 1'b0, 1'b1, 4'h3); tick(1'b0, 5'd0, 32'd0);
    bus.ex_ready = 1'b1;
    idle(3);

    // x3 stale in the regfile, younger writers in MEM (0x55) and WB (0x66)
    rf[3] = 32'd0;
    tick(1'b1, 5'd3, 32'h66);
    drive_op(5'd3, 5'd0, 5'd14, 32'h300, 32'd0, 1'b0, 1'b0, 4'h4);
    tick(1'b1, 5'd3, 32'h55);
    idle(3);

    // x0 as source with a writer targeting x0, then a negative immediate
    tick(1'b1, 5'd0, 32'hFF);
    drive_op(5'd0, 5'd0, 5'd15, 32'h400, 32'd0, 1'b0, 1'b0, 4'h5);
    tick(1'b1, 5'd0, 32'hFF);
    drive_op(5'd1, 5'd0, 5'd16, 32'h404, 32'hFFFF_FFFC, 1'b0, 1'b1, 4'h6);
    tick(1'b0, 5'd0, 32'd0);
    idle(2);

    // fill to two, then flush together with ex_ready: nothing may emerge
    bus.ex_ready = 1'b0;
    drive_op(5'd1, 5'd2, 5'd17, 32'h500, 32'd0, 1'b0, 1'b0, 4'h7); tick(1'b0, 5'd0, 32'd0);
    drive_op(5'd2, 5'd1, 5'd18, 32'h504, 32'd0, 1'b0, 1'b0, 4'h8); tick(1'b0, 5'd0, 32'd0);
    bus.ex_ready = 1'b1;
    bus.flush = 1'b1;
    tick(1'b0, 5'd0, 32'd0);
    idle(2);

    // randomized traffic with hazards concentrated on x0..x7
    for (int i = 0; i < 3000; i++) begin
      drive_op(5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 31)),
               $urandom, $urandom, ($urandom_range(0, 4) == 0), ($urandom_range(0, 2) == 0),
               4'($urandom_range(0, 15)));
      bus.id_valid = ($urandom_range(0, 9) < 7);
      bus.ex_ready = ($urandom_range(0, 9) < 6);
      bus.flush    = ($urandom_range(0, 29) == 0);
      tick(($urandom_range(0, 9) < 7), 5'($urandom_range(0, 7)), $urandom);
    end
    bus.ex_ready = 1'b1;
    idle(4);

    // asynchronous reset in the middle of held traffic
    bus.ex_ready = 1'b0;
    drive_op(5'd1, 5'd2, 5'd19, 32'h600, 32'd0, 1'b1, 1'b1, 4'h9); tick(1'b0, 5'd0, 32'd0);
    drive_op(5'd3, 5'd4, 5'd20, 32'h604, 32'd0, 1'b1, 1'b1, 4'hA); tick(1'b0, 5'd0, 32'd0);
    #2;
    nRst = 1'b0;
    #1;
    check("async reset ex_valid", {31'd0, bus.ex_valid}, 32'd0);
    check("async reset id_ready", {31'd0, bus.id_ready}, 32'd1);
    check("async reset alu_input_a", bus.alu_input_a, 32'd0);
    check("async reset alu_input_b", bus.alu_input_b, 32'd0);
    sb.delete();
    idle(2);
    nRst = 1'b1;
    bus.ex_ready = 1'b1;
    idle(3);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
